// File: rtl/sync_edge_rate_meter_pkg.sv
// -----------------------------------------------------------------------------
// sync_meter_pkg
// Shared types and helpers for the edge-rate meter.
//   meter_state_t : gate FSM encoding (IDLE, GATE)
//   sat_inc()     : saturating +1 used by the window accumulator
// -----------------------------------------------------------------------------
package sync_meter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } meter_state_t;

    // Argument width of sat_inc; callers cast their narrower counts into it.
    localparam int unsigned SAT_ARG_W = 32;

    // Increment that sticks at max_val instead of wrapping to zero.
    function automatic logic [SAT_ARG_W-1:0] sat_inc(
        input logic [SAT_ARG_W-1:0] val,
        input logic [SAT_ARG_W-1:0] max_val
    );
        logic [SAT_ARG_W-1:0] res;
        if (val >= max_val) begin
            res = max_val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_edge_rate_meter_if.sv
// -----------------------------------------------------------------------------
// sync_edge_rate_meter_if
// One-entry valid/ready result channel of the edge-rate meter.
//   count_valid : producer -> consumer, an unconsumed result is held
//   count_ready : consumer -> producer, result accepted when valid is high
//   count_data  : producer -> consumer, edge count of the completed window
//   count_sat   : producer -> consumer, window count saturated
// Modports: master (meter side), slave (consumer side).
// -----------------------------------------------------------------------------
interface sync_edge_rate_meter_if #(
    parameter int CNT_W = 16
);
    logic             count_valid;
    logic             count_ready;
    logic [CNT_W-1:0] count_data;
    logic             count_sat;

    modport master (
        output count_valid,
        output count_data,
        output count_sat,
        input  count_ready
    );

    modport slave (
        input  count_valid,
        input  count_data,
        input  count_sat,
        output count_ready
    );
endinterface

// File: rtl/sync_edge_rate_meter_rise_edge_detect.sv
// -----------------------------------------------------------------------------
// rise_edge_detect
// Registers the previous sample of an already-synchronous signal and flags
// the cycle on which it goes 0 -> 1. A held-high level flags exactly once.
//   i_clk   : clock (rising edge)
//   i_rst_n : synchronous active-low reset, clears the history to 0
//   i_sig   : sampled signal, already in the i_clk domain
//   o_rise  : high for the cycle where i_sig=1 and the previous sample was 0
// -----------------------------------------------------------------------------
module rise_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // History register: previous-cycle sample of i_sig.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/sync_edge_rate_meter.sv
// -----------------------------------------------------------------------------
// sync_edge_rate_meter
// Counts rising edges of sync_sig over back-to-back gate windows of
// GATE_CYCLES clocks and offers each window's count through a one-entry
// valid/ready output register.
//   outclk   : sole clock, rising edge
//   reset_n  : synchronous active-low reset
//   sync_sig : signal to measure, already in the outclk domain
//   enable   : 1 = measure, 0 = idle / abort the current window
//   count_if : master side of the result channel (valid/ready/data/sat)
//   dropped  : sticky, a finished window was lost because the output was full;
//              cleared when measurement is (re)started from idle
// -----------------------------------------------------------------------------
module sync_edge_rate_meter
    import sync_meter_pkg::*;
#(
    parameter  int GATE_CYCLES = 1000,
    parameter  int CNT_W       = 16,
    localparam int GATE_W      = $clog2(GATE_CYCLES)
) (
    input  logic                    outclk,
    input  logic                    reset_n,
    input  logic                    sync_sig,
    input  logic                    enable,
    sync_edge_rate_meter_if.master  count_if,
    output logic                    dropped
);

    localparam logic [CNT_W-1:0]  ACC_MAX    = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] TIMER_LAST = GATE_W'(GATE_CYCLES - 1);

    meter_state_t      r_state;
    meter_state_t      w_state_nxt;
    logic [GATE_W-1:0] r_timer;
    logic [CNT_W-1:0]  r_acc;
    logic              r_sat;
    logic              r_valid;
    logic [CNT_W-1:0]  r_data;
    logic              r_data_sat;
    logic              r_dropped;

    logic              w_rise;
    logic              w_count_en;
    logic              w_final;
    logic              w_clr_drop;
    logic [CNT_W-1:0]  w_acc_inc;
    logic              w_acc_at_max;
    logic [CNT_W-1:0]  w_final_data;
    logic              w_final_sat;
    logic              w_accept;
    logic              w_load;

    rise_edge_detect u_rise (
        .i_clk   (outclk),
        .i_rst_n (reset_n),
        .i_sig   (sync_sig),
        .o_rise  (w_rise)
    );

    assign w_acc_inc    = CNT_W'(sat_inc(SAT_ARG_W'(r_acc), SAT_ARG_W'(ACC_MAX)));
    assign w_acc_at_max = (r_acc == ACC_MAX);

    // An edge on the last gate cycle still belongs to the closing window.
    assign w_final_data = w_rise ? w_acc_inc : r_acc;
    assign w_final_sat  = r_sat | (w_rise & w_acc_at_max);

    assign w_accept = r_valid & count_if.count_ready;
    assign w_load   = w_final & (~r_valid | w_accept);

    // FSM state register.
    always_ff @(posedge outclk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: enable alone decides between idle and gating.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = GATE;
                else        w_state_nxt = IDLE;
            end
            GATE: begin
                if (enable) w_state_nxt = GATE;
                else        w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode: counting, window close and dropped-clear strobes.
    always_comb begin
        w_count_en = 1'b0;
        w_final    = 1'b0;
        w_clr_drop = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_clr_drop = 1'b1;
                else        w_clr_drop = 1'b0;
            end
            GATE: begin
                if (enable) begin
                    w_count_en = 1'b1;
                    w_final    = (r_timer == TIMER_LAST);
                end else begin
                    w_count_en = 1'b0;
                    w_final    = 1'b0;
                end
            end
            default: begin
                w_count_en = 1'b0;
                w_final    = 1'b0;
                w_clr_drop = 1'b0;
            end
        endcase
    end

    // Gate timer and edge accumulator; reload on window close so the next
    // window starts immediately, clear whenever not counting.
    always_ff @(posedge outclk) begin
        if (!reset_n) begin
            r_timer <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
        end else if (w_count_en) begin
            if (w_final) begin
                r_timer <= '0;
                r_acc   <= '0;
                r_sat   <= 1'b0;
            end else begin
                r_timer <= r_timer + GATE_W'(1);
                if (w_rise) begin
                    r_acc <= w_acc_inc;
                    r_sat <= r_sat | w_acc_at_max;
                end else begin
                    r_acc <= r_acc;
                    r_sat <= r_sat;
                end
            end
        end else begin
            r_timer <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
        end
    end

    // One-entry output register plus the sticky dropped flag.
    always_ff @(posedge outclk) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_data_sat <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_data     <= w_final_data;
                r_data_sat <= w_final_sat;
            end else if (w_accept) begin
                r_valid    <= 1'b0;
            end else begin
                r_valid    <= r_valid;
            end

            // A close with the register full and not drained is lost.
            if (w_final && !w_load) begin
                r_dropped <= 1'b1;
            end else if (w_clr_drop) begin
                r_dropped <= 1'b0;
            end else begin
                r_dropped <= r_dropped;
            end
        end
    end

    assign count_if.count_valid = r_valid;
    assign count_if.count_data  = r_data;
    assign count_if.count_sat   = r_data_sat;
    assign dropped              = r_dropped;

endmodule

// File: tb/tb_sync_edge_rate_meter.sv
// -----------------------------------------------------------------------------
// tb_sync_edge_rate_meter
// Two meters share one stimulus stream: A (10-cycle gate) and B (40-cycle
// gate, so a fast input saturates the 4-bit count). A reference model counts
// window samples and edges arithmetically and pushes expected results into
// per-meter queues; a negedge monitor pops on every handshake and also
// checks the visible output state every cycle.
// -----------------------------------------------------------------------------
module tb_sync_edge_rate_meter;

    localparam int CW = 4;

    logic outclk = 1'b0;
    logic reset_n;
    logic sync_sig;
    logic enable;
    logic rdy;
    logic drop_a;
    logic drop_b;

    always #5 outclk = ~outclk;

    sync_edge_rate_meter_if #(.CNT_W(CW)) if_a ();
    sync_edge_rate_meter_if #(.CNT_W(CW)) if_b ();

    assign if_a.count_ready = rdy;
    assign if_b.count_ready = rdy;

    sync_edge_rate_meter #(.GATE_CYCLES(10), .CNT_W(CW)) dut_a (
        .outclk   (outclk),
        .reset_n  (reset_n),
        .sync_sig (sync_sig),
        .enable   (enable),
        .count_if (if_a),
        .dropped  (drop_a)
    );

    sync_edge_rate_meter #(.GATE_CYCLES(40), .CNT_W(CW)) dut_b (
        .outclk   (outclk),
        .reset_n  (reset_n),
        .sync_sig (sync_sig),
        .enable   (enable),
        .count_if (if_b),
        .dropped  (drop_b)
    );

    logic          dv [2];
    logic [CW-1:0] dd [2];
    logic          ds [2];
    logic          dk [2];
    assign dv[0] = if_a.count_valid; assign dd[0] = if_a.count_data;
    assign ds[0] = if_a.count_sat;   assign dk[0] = drop_a;
    assign dv[1] = if_b.count_valid; assign dd[1] = if_b.count_data;
    assign ds[1] = if_b.count_sat;   assign dk[1] = drop_b;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Reference model state per meter.
    int            gc [2] = '{10, 40};
    bit            m_gate [2];
    int            m_len [2];
    int            m_edges [2];
    bit            m_prev [2];
    bit            m_valid [2];
    bit            m_drop [2];
    logic [CW-1:0] m_data [2];
    bit            m_sat [2];
    // Snapshot of what the DUT should be showing until the next edge.
    bit            v_valid [2];
    bit            v_drop [2];
    logic [CW-1:0] v_data [2];
    bit            v_sat [2];
    logic [CW:0]   eq0 [$];
    logic [CW:0]   eq1 [$];

    task automatic check(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step(input int k);
        bit   e;
        bit   acc;
        bit   fin;
        int   cnt;
        logic [CW-1:0] rd;
        bit   rs;
        v_valid[k] = m_valid[k]; v_drop[k] = m_drop[k];
        v_data[k]  = m_data[k];  v_sat[k]  = m_sat[k];
        fin = 1'b0; rd = '0; rs = 1'b0;
        if (!reset_n) begin
            m_gate[k] = 1'b0; m_len[k] = 0; m_edges[k] = 0; m_prev[k] = 1'b0;
            m_valid[k] = 1'b0; m_drop[k] = 1'b0; m_data[k] = '0; m_sat[k] = 1'b0;
            if (k == 0) eq0.delete(); else eq1.delete();
        end else begin
            e   = sync_sig && !m_prev[k];
            m_prev[k] = sync_sig;
            acc = m_valid[k] && rdy;
            if (!m_gate[k]) begin
                if (enable) begin
                    m_gate[k] = 1'b1; m_drop[k] = 1'b0; m_len[k] = 0; m_edges[k] = 0;
                end
            end else if (!enable) begin
                m_gate[k] = 1'b0; m_len[k] = 0; m_edges[k] = 0;
            end else begin
                m_len[k]++;
                m_edges[k] += int'(e);
                if (m_len[k] == gc[k]) begin
                    fin = 1'b1;
                    cnt = m_edges[k];
                    rs  = (cnt > 15);
                    rd  = rs ? 4'd15 : CW'(cnt);
                    m_len[k] = 0; m_edges[k] = 0;
                end
            end
            if (fin && (!m_valid[k] || acc)) begin
                m_valid[k] = 1'b1; m_data[k] = rd; m_sat[k] = rs;
                if (k == 0) eq0.push_back({rd, rs}); else eq1.push_back({rd, rs});
            end else begin
                if (fin) m_drop[k] = 1'b1;
                if (acc) m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic s, input logic en, input logic r, input logic rn);
        sync_sig = s; enable = en; rdy = r; reset_n = rn;
        model_step(0);
        model_step(1);
        @(posedge outclk); #1;
    endtask

    task automatic pop_check(input int k);
        logic [CW:0] ex;
        bit          empty;
        ex = '0;
        if (k == 0) begin
            empty = (eq0.size() == 0);
            if (!empty) ex = eq0.pop_front();
        end else begin
            empty = (eq1.size() == 0);
            if (!empty) ex = eq1.pop_front();
        end
        if (empty) begin
            total++; bad++;
            $display("FAIL sb_unexpected[%0d] @%0t: got data=%0d sat=%0d expected no result",
                     k, $time, dd[k], ds[k]);
        end else begin
            check("sb_data", k, int'(dd[k]), int'(ex[CW:1]));
            check("sb_sat",  k, int'(ds[k]), int'(ex[0]));
        end
    endtask

    // Monitor: outputs are stable at negedge; handshake completes at next posedge.
    always @(negedge outclk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check("valid",   k, int'(dv[k]), int'(v_valid[k]));
                check("dropped", k, int'(dk[k]), int'(v_drop[k]));
                check("data",    k, int'(dd[k]), int'(v_data[k]));
                check("sat",     k, int'(ds[k]), int'(v_sat[k]));
                if (dv[k] && rdy && reset_n) pop_check(k);
            end
        end
    end

    initial begin
        logic s;
        int   dens;
        reset_n = 1'b0; enable = 1'b0; sync_sig = 1'b0; rdy = 1'b0;
        @(posedge outclk); #1;
        started = 1'b1;

        // Reset held with sync_sig toggling.
        for (int i = 0; i < 3; i++) step(1'(i % 2), 1'b1, 1'b1, 1'b0);

        // Steady toggle: A sees 5 edges per window, B saturates (20 edges).
        s = 1'b0;
        for (int i = 0; i < 85; i++) begin s = ~s; step(s, 1'b1, 1'b1, 1'b1); end

        // Level hold: one rise, then a long high level.
        for (int i = 0; i < 7; i++)  step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 1'b1);

        // Sparse pulses: B gets a small unsaturated count.
        for (int i = 0; i < 80; i++) step(1'((i % 13) == 0), 1'b1, 1'b1, 1'b1);

        // Backpressure: hold result, drop later windows, then drain.
        for (int i = 0; i < 25; i++) begin s = ~s; step(s, 1'b1, 1'b0, 1'b1); end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b1, 1'b1);

        // Abort mid-window, then a rise exactly on A's last gate cycle.
        for (int i = 0; i < 6; i++)  begin s = ~s; step(s, 1'b1, 1'b1, 1'b1); end
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++)  step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1);

        // Reset while a result is held and a window is in progress.
        for (int i = 0; i < 17; i++) begin s = ~s; step(s, 1'b1, 1'b0, 1'b1); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);

        // Randomized traffic with varying edge density and backpressure.
        for (int i = 0; i < 2000; i++) begin
            case ((i / 200) % 4)
                0:       dens = 50;
                1:       dens = 10;
                2:       dens = 90;
                default: dens = 30;
            endcase
            step(1'($urandom_range(0, 99) < dens),
                 1'($urandom_range(0, 149) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 499) != 0));
        end

        // Drain: stop measuring and accept whatever is held.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("drain", 0, eq0.size(), 0);
        check("drain", 1, eq1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_edge_rate_meter.md
Name: sync_edge_rate_meter

Overview:
- Downstream consumer of the async-signal synchronizer/edge detector.
- Takes the synchronizer's out_sync_sig in the outclk domain and counts its rising edges over fixed back-to-back gate windows of GATE_CYCLES clocks.
- Presents each window's count through a one-entry valid/ready output register. The result is a pulse-rate measurement for display/control logic.

Parameters:
- GATE_CYCLES, 1000: window length in outclk cycles; must be >= 2.
- CNT_W, 16: width of the edge count.
- GATE_W, $clog2(GATE_CYCLES): gate timer width; derived, not overridden.

Ports:
- outclk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on outclk rising edge.
- sync_sig  in  1  synchronized signal from the edge detector; already in the outclk domain; no further synchronizing here.
- enable  in  1  1 = measure; 0 = idle/abort.
- count_ready  in  1  consumer accepts count_data when count_valid=1.
- count_valid  out  1  output register holds an unconsumed result.
- count_data  out  CNT_W  edge count of the completed window.
- count_sat  out  1  window count saturated; qualified by count_valid.
- dropped  out  1  sticky: a completed window was discarded because the output register was full.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE.
  - timer, accumulator, count_data, count_sat, count_valid, dropped all = 0.
  - sync_sig history register = 0.
  - Reset mid-window discards the partial count and any held result.
- Edge detect:
  - prev <= sync_sig every cycle.
  - edge = sync_sig & ~prev.
  - A level held high counts once; a single-cycle high pulse counts once.
- FSM states: IDLE, GATE.
- IDLE:
  - timer=0, accumulator=0.
  - On enable=1: go to GATE next cycle and clear dropped.
- GATE:
  - timer increments each cycle, 0 .. GATE_CYCLES-1.
  - On each edge, accumulator += 1, saturating at 2^CNT_W-1; a saturating increment sets the internal sat bit.
  - On the final cycle (timer==GATE_CYCLES-1):
    - An edge on that cycle is included.
    - Final value = accumulator plus that edge.
    - Timer and accumulator reload to 0 / sat=0; the next window starts the following cycle with no dead cycle.
  - enable=0 during GATE, including on the final cycle: abort to IDLE next cycle; partial count discarded, no result produced. The output register is unaffected.
- Output register (one entry):
  - Load at the final gate cycle edge when count_valid=0 OR (count_valid & count_ready) in that same cycle.
  - After load, count_valid=1 on the following cycle, with count_data/count_sat = final value.
  - Latency: result visible 1 cycle after the final gate cycle.
  - If full and not consumed that cycle: result discarded, dropped <= 1 (sticky). The held result is unchanged.
  - count_valid & count_ready with no load: count_valid <= 0. count_data holds its last value.
  - count_data and count_sat are stable while count_valid=1 and count_ready=0.
- Widths:
  - Accumulator is CNT_W bits.
  - Timer is GATE_W bits and never exceeds GATE_CYCLES-1.

Decomposition:
- Package sync_meter_pkg:
  - typedef enum {IDLE, GATE} meter_state_t.
  - Helper function for saturating increment.
- One sub-module: rise_edge_detect (registered prev + edge output). Kept separate for reuse by other sync-domain consumers.
- Output register stays inline.

Test Plan:
- Reset: reset_n=0 for 3 cycles, sync_sig toggling -> count_valid=0, count_data=0, count_sat=0, dropped=0 throughout and on the first cycle after release.
- Steady rate (GATE_CYCLES=10, CNT_W=4):
  - Stimulus: sync_sig toggles every cycle (edge every 2 cycles), enable=1, count_ready=1.
  - Response: count_valid one-cycle pulse every 10 cycles, count_data=5, count_sat=0.
- Level hold:
  - Stimulus: sync_sig rises at window cycle 3 and stays high 20 cycles.
  - Response: first window count=1, next window count=0.
  - Final-cycle check: a rise exactly at timer=9 is counted in that window (count=1).
- Saturation (GATE_CYCLES=40, CNT_W=4):
  - Stimulus: edge every 2 cycles (20 edges).
  - Response: count_data=15, count_sat=1; next window with 3 edges gives count_data=3, count_sat=0.
- Backpressure (GATE_CYCLES=10):
  - Stimulus: count_ready=0 for 25 cycles.
  - Response: first result held stable, second window discarded, dropped=1.
  - Then: count_ready=1 consumes the held result; dropped stays 1 until enable 0->1.
- Abort/reset mid-window:
  - Stimulus: enable=0 at timer=5 -> no count_valid; re-enable -> fresh full window, count exact.
  - Stimulus: reset_n=0 at timer=7 with count_valid=1 -> all outputs 0 next cycle.
